// File: rtl/commit_writeback_ctrl_pkg.sv
// Shared constants, FSM state type and helpers for the commit/writeback controller.
package commit_writeback_ctrl_pkg;
  localparam int NR_COMMIT_PORTS = 2;
  localparam int REG_ADDR_W      = 5;

  typedef enum logic [0:0] {
    ST_RUN        = 1'b0,
    ST_WAIT_FLUSH = 1'b1
  } cwb_state_e;

  // GPR x0 is hardwired zero and is never written; FPR f0 is a real register.
  function automatic logic writes_reg(input logic fpr, input logic [REG_ADDR_W-1:0] rd);
    return fpr | (rd != '0);
  endfunction
endpackage

// File: rtl/commit_writeback_ctrl_conflict_chk.sv
// Same-cycle destination clash between the two commit head entries.
module commit_conflict_chk
  import commit_writeback_ctrl_pkg::*;
#(
  parameter int NUM_THREADS_LOG = 1
) (
  input  logic [NR_COMMIT_PORTS-1:0]                       drop,
  input  logic [NR_COMMIT_PORTS-1:0]                       fpr,
  input  logic [NR_COMMIT_PORTS-1:0][REG_ADDR_W-1:0]       rd,
  input  logic [NR_COMMIT_PORTS-1:0][NUM_THREADS_LOG-1:0]  tid,
  output logic                                             conflict
);
  assign conflict = ~drop[0] & ~drop[1] &
                    (tid[0] == tid[1]) & (fpr[0] == fpr[1]) & (rd[0] == rd[1]) &
                    writes_reg(fpr[0], rd[0]);
endmodule

// File: rtl/commit_writeback_ctrl.sv
// Commit/writeback controller: retires up to two scoreboard head entries per cycle.
// Build macro COMMIT_PERF_CNT_EN adds per-thread retired-instruction counters.
module commit_writeback_ctrl #(
  parameter int XLEN            = 64,
  parameter int NUM_THREADS_LOG = 1,
  parameter int NR_COMMIT_PORTS = 2
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic [NR_COMMIT_PORTS-1:0]                       commit_valid_i,
  input  logic [NR_COMMIT_PORTS-1:0]                       commit_drop_i,
  input  logic [NR_COMMIT_PORTS-1:0]                       commit_ex_i,
  input  logic [NR_COMMIT_PORTS-1:0][4:0]                  commit_rd_i,
  input  logic [NR_COMMIT_PORTS-1:0]                       commit_fpr_i,
  input  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]             commit_result_i,
  input  logic [NR_COMMIT_PORTS-1:0][NUM_THREADS_LOG-1:0]  commit_tid_i,
  input  logic                                             halt_i,
  input  logic                                             flush_i,
  output logic [NR_COMMIT_PORTS-1:0]                       commit_ack_o,
  output logic [NR_COMMIT_PORTS-1:0][4:0]                  waddr_o,
  output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]             wdata_o,
  output logic [NR_COMMIT_PORTS-1:0]                       we_gpr_o,
  output logic [NR_COMMIT_PORTS-1:0]                       we_fpr_o,
  output logic [NR_COMMIT_PORTS-1:0][NUM_THREADS_LOG-1:0]  wb_thread_id_o,
  output logic                                             exception_valid_o,
  output logic [NUM_THREADS_LOG-1:0]                       exception_tid_o,
  output logic [(2**NUM_THREADS_LOG)-1:0][63:0]            retired_cnt_o
);
  import commit_writeback_ctrl_pkg::*;

  localparam int NT = 2**NUM_THREADS_LOG;

  cwb_state_e                  state_q;
  logic                        run_ok;
  logic                        conflict;
  logic                        take_ex;
  logic [NR_COMMIT_PORTS-1:0]  ack;
  logic [NR_COMMIT_PORTS-1:0]  retire;

  commit_conflict_chk #(.NUM_THREADS_LOG(NUM_THREADS_LOG)) u_conflict_chk (
    .drop     (commit_drop_i),
    .fpr      (commit_fpr_i),
    .rd       (commit_rd_i),
    .tid      (commit_tid_i),
    .conflict (conflict)
  );

  // Port 1 is younger: it may only retire alongside a clean port-0 retirement.
  always_comb begin
    run_ok  = (state_q == ST_RUN) & ~halt_i & ~flush_i & ~rst_i;
    ack     = '0;
    ack[0]  = run_ok & commit_valid_i[0];
    ack[1]  = ack[0] & ~commit_ex_i[0] & commit_valid_i[1] & ~commit_ex_i[1] & ~conflict;
    retire  = ack & ~commit_drop_i & ~commit_ex_i;
    take_ex = ack[0] & commit_ex_i[0] & ~commit_drop_i[0];
  end

  assign commit_ack_o = ack;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:        if (take_ex) state_q <= ST_WAIT_FLUSH;
        ST_WAIT_FLUSH: if (flush_i) state_q <= ST_RUN;
        default:       state_q <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      waddr_o           <= '0;
      wdata_o           <= '0;
      we_gpr_o          <= '0;
      we_fpr_o          <= '0;
      wb_thread_id_o    <= '0;
      exception_valid_o <= 1'b0;
      exception_tid_o   <= '0;
    end else begin
      for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
        we_gpr_o[p] <= retire[p] & ~commit_fpr_i[p] & (commit_rd_i[p] != 5'd0);
        we_fpr_o[p] <= retire[p] & commit_fpr_i[p];
        if (retire[p]) begin
          waddr_o[p]        <= commit_rd_i[p];
          wdata_o[p]        <= commit_result_i[p];
          wb_thread_id_o[p] <= commit_tid_i[p];
        end
      end
      exception_valid_o <= take_ex;
      if (take_ex) exception_tid_o <= commit_tid_i[0];
    end
  end

`ifdef COMMIT_PERF_CNT_EN
  logic [NT-1:0][63:0] cnt_q;
  logic [NT-1:0][1:0]  cnt_inc;

  always_comb begin
    cnt_inc = '0;
    for (int t = 0; t < NT; t++)
      for (int p = 0; p < NR_COMMIT_PORTS; p++)
        if (retire[p] && (commit_tid_i[p] == NUM_THREADS_LOG'(t)))
          cnt_inc[t] = cnt_inc[t] + 2'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      for (int t = 0; t < NT; t++) cnt_q[t] <= cnt_q[t] + 64'(cnt_inc[t]);
    end
  end

  assign retired_cnt_o = cnt_q;
`else
  assign retired_cnt_o = '0;
`endif
endmodule
